// File: rtl/game_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_timer_ctrl
// Brief    : Game sequencer (get-ready countdown, run, pause, game over)
//            driving a BCD minute down-timer.
// Revision : 1.0 - initial release
// ============================================================================
module game_timer_ctrl #(
  parameter int READY_TICKS = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic       timer_clr,
  output logic       timer_cnt,
  output logic       game_active,
  output logic       game_over,
  output logic [1:0] ready_left,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [1:0] READY_INIT = 2'(READY_TICKS);

  logic [2:0] state_q, state_d;
  logic       timer_clr_q, timer_clr_d;
  logic       timer_cnt_q, timer_cnt_d;
  logic       game_active_q, game_active_d;
  logic       game_over_q, game_over_d;
  logic [1:0] ready_left_q, ready_left_d;
  logic       armed_q, armed_d;
  logic       expire;

  // armed blocks expiry on the stale 00 reading until the first count step
  assign expire = armed_q && (tens == 4'd0) && (ones == 4'd0);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= S_IDLE;
      timer_clr_q   <= 1'b1;
      timer_cnt_q   <= 1'b0;
      game_active_q <= 1'b0;
      game_over_q   <= 1'b0;
      ready_left_q  <= 2'd0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_clr_q   <= timer_clr_d;
      timer_cnt_q   <= timer_cnt_d;
      game_active_q <= game_active_d;
      game_over_q   <= game_over_d;
      ready_left_q  <= ready_left_d;
      armed_q       <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_READY;
      S_READY: if (tick && ready_left_q == 2'd1) state_d = S_RUN;
      S_RUN: begin
        if (expire)     state_d = S_OVER;
        else if (pause) state_d = S_PAUSE;
      end
      S_PAUSE: if (pause) state_d = S_RUN;
      S_OVER:  if (start) state_d = S_READY;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_left_d  = ready_left_q;
    armed_d       = armed_q;
    timer_cnt_d   = 1'b0;
    timer_clr_d   = (state_d == S_IDLE) || (state_d == S_READY) || (state_d == S_OVER);
    game_active_d = (state_d == S_RUN);
    game_over_d   = (state_d == S_OVER);
    case (state_q)
      S_IDLE, S_OVER: if (start) ready_left_d = READY_INIT;
      S_READY: begin
        if (tick) begin
          if (ready_left_q == 2'd1) begin
            ready_left_d = 2'd0;
            armed_d      = 1'b0;
          end else begin
            ready_left_d = ready_left_q - 2'd1;
          end
        end
      end
      S_RUN: begin
        if (!expire && !pause && tick && !timer_cnt_q) begin
          timer_cnt_d = 1'b1;
          armed_d     = 1'b1;
        end
      end
      default: ;
    endcase
    if (state_d == S_IDLE) begin
      ready_left_d = 2'd0;
      armed_d      = 1'b0;
    end
  end

  assign timer_clr   = timer_clr_q;
  assign timer_cnt   = timer_cnt_q;
  assign game_active = game_active_q;
  assign game_over   = game_over_q;
  assign ready_left  = ready_left_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_game_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_timer_ctrl
// Brief    : Scenario bench for game_timer_ctrl with an expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_timer_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] tens = 4'd0;
  logic [3:0] ones = 4'd0;
  logic       timer_clr, timer_cnt, game_active, game_over;
  logic [1:0] ready_left;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  string      tag_q[$];

  game_timer_ctrl #(.READY_TICKS(3)) u_dut (
    .clk        (clk),
    .clr        (clr),
    .tick       (tick),
    .start      (start),
    .pause      (pause),
    .tens       (tens),
    .ones       (ones),
    .timer_clr  (timer_clr),
    .timer_cnt  (timer_cnt),
    .game_active(game_active),
    .game_over  (game_over),
    .ready_left (ready_left),
    .state      (state)
  );

  always #5 clk = ~clk;

  // packed view: {state, ready_left, timer_clr, timer_cnt, game_active, game_over}
  function automatic logic [8:0] pk(input logic [2:0] st, input logic [1:0] rl,
                                    input logic tc, input logic cn,
                                    input logic ac, input logic ov);
    return {st, rl, tc, cn, ac, ov};
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got st=%0d rl=%0d clr=%b cnt=%b act=%b over=%b, expected st=%0d rl=%0d clr=%b cnt=%b act=%b over=%b",
               tag, obs[8:6], obs[5:4], obs[3], obs[2], obs[1], obs[0],
               expv[8:6], expv[5:4], expv[3], expv[2], expv[1], expv[0]);
    end
  endtask

  // one clk of stimulus; expectation is queued with the stimulus, checked after the edge
  task automatic step(input string tag, input logic t, input logic s, input logic p,
                      input logic c, input logic [8:0] expv);
    @(negedge clk);
    tick = t; start = s; pause = p; clr = c;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    tick = 1'b0; start = 1'b0; pause = 1'b0; clr = 1'b0;
    check(tag_q.pop_front(), {state, ready_left, timer_clr, timer_cnt, game_active, game_over},
          exp_q.pop_front());
  endtask

  localparam logic [2:0] I = 3'd0, R = 3'd1, U = 3'd2, P = 3'd3, O = 3'd4;

  initial begin
    //               tag                 tk st pa cl
    step("reset",            0, 0, 0, 1, pk(I, 2'd0, 1, 0, 0, 0));
    step("idle_pause",       0, 0, 1, 0, pk(I, 2'd0, 1, 0, 0, 0));
    step("start_wins",       0, 1, 1, 0, pk(R, 2'd3, 1, 0, 0, 0));
    step("ready_hold",       0, 0, 0, 0, pk(R, 2'd3, 1, 0, 0, 0));
    step("ready_tick1",      1, 1, 0, 0, pk(R, 2'd2, 1, 0, 0, 0));
    step("ready_tick2",      1, 0, 1, 0, pk(R, 2'd1, 1, 0, 0, 0));
    step("ready_to_run",     1, 0, 0, 0, pk(U, 2'd0, 0, 0, 1, 0));
    step("no_early_expiry",  0, 0, 0, 0, pk(U, 2'd0, 0, 0, 1, 0));
    tens = 4'd5; ones = 4'd9;
    step("run_tick_cnt",     1, 0, 0, 0, pk(U, 2'd0, 0, 1, 1, 0));
    step("cnt_one_cycle",    0, 1, 0, 0, pk(U, 2'd0, 0, 0, 1, 0));
    step("pause_beats_tick", 1, 0, 1, 0, pk(P, 2'd0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      step("pause_tick",     1, 0, 0, 0, pk(P, 2'd0, 0, 0, 0, 0));
    step("resume",           0, 0, 1, 0, pk(U, 2'd0, 0, 0, 1, 0));
    step("resume_tick_cnt",  1, 0, 0, 0, pk(U, 2'd0, 0, 1, 1, 0));
    tens = 4'd0; ones = 4'd0;
    step("expiry_beats_pause", 0, 0, 1, 0, pk(O, 2'd0, 1, 0, 0, 1));
    step("over_pause",       0, 0, 1, 0, pk(O, 2'd0, 1, 0, 0, 1));
    step("over_tick",        1, 0, 0, 0, pk(O, 2'd0, 1, 0, 0, 1));
    step("over_restart",     0, 1, 0, 0, pk(R, 2'd3, 1, 0, 0, 0));
    step("ready2_tick",      1, 0, 0, 0, pk(R, 2'd2, 1, 0, 0, 0));
    step("clr_in_ready",     1, 0, 0, 1, pk(I, 2'd0, 1, 0, 0, 0));
    step("start2",           0, 1, 0, 0, pk(R, 2'd3, 1, 0, 0, 0));
    step("r2_t1",            1, 0, 0, 0, pk(R, 2'd2, 1, 0, 0, 0));
    step("r2_t2",            1, 0, 0, 0, pk(R, 2'd1, 1, 0, 0, 0));
    step("r2_run",           1, 0, 0, 0, pk(U, 2'd0, 0, 0, 1, 0));
    step("rearm_cleared",    0, 0, 0, 0, pk(U, 2'd0, 0, 0, 1, 0));
    tens = 4'd5; ones = 4'd9;
    step("r2_tick_cnt",      1, 0, 0, 0, pk(U, 2'd0, 0, 1, 1, 0));
    tens = 4'd0; ones = 4'd0;
    step("plain_expiry",     0, 0, 0, 0, pk(O, 2'd0, 1, 0, 0, 1));
    step("start3",           0, 1, 0, 0, pk(R, 2'd3, 1, 0, 0, 0));
    step("r3_t1",            1, 0, 0, 0, pk(R, 2'd2, 1, 0, 0, 0));
    step("r3_t2",            1, 0, 0, 0, pk(R, 2'd1, 1, 0, 0, 0));
    step("r3_run",           1, 0, 0, 0, pk(U, 2'd0, 0, 0, 1, 0));
    tens = 4'd3; ones = 4'd0;
    step("clr_with_tick_run", 1, 0, 0, 1, pk(I, 2'd0, 1, 0, 0, 0));
    step("idle_after_clr",   1, 0, 0, 0, pk(I, 2'd0, 1, 0, 0, 0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
